// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the programmable serial pattern detector.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with overlap / non-overlap modes.
//   state    | meaning
//   ST_IDLE  | unconfigured, input bits ignored
//   ST_FILL  | fewer than len bits accepted since the last clear
//   ST_ARMED | history holds at least len valid bits
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       inbits,
    input  logic                       cfg_load,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       cnt_clr,
    output logic                       detect,
    output logic [CNT_W-1:0]           match_count,
    output logic                       cfg_err,
    output logic                       armed
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               detect_q, detect_d;
    logic               cfg_err_q, cfg_err_d;
    logic               armed_q, armed_d;

    logic               accept;
    logic               len_ok;
    logic               load_ok;
    logic               match;
    logic [PAT_W-1:0]   hist_shift;
    logic [PAT_W-1:0]   len_mask;
    logic [LEN_W-1:0]   fill_inc;

    assign accept     = in_valid && (state_q != ST_IDLE);
    assign len_ok     = (cfg_len != '0) && (int'(cfg_len) <= PAT_W);
    assign load_ok    = cfg_load && len_ok;
    assign hist_shift = {hist_q[PAT_W-2:0], inbits};
    assign fill_inc   = fill_q + LEN_W'(1);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Match always uses the configuration in force before any same-cycle load.
    assign match = accept
                && ((state_q == ST_ARMED) || (fill_inc == len_q))
                && ((hist_shift & len_mask) == (pat_q & len_mask));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= LEN_W'(1);
            ovl_q     <= 1'b0;
            detect_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            detect_q  <= detect_d;
            cfg_err_q <= cfg_err_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        if (accept) begin
            hist_d = hist_shift;
            if (state_q == ST_FILL) begin
                fill_d = fill_inc;
                if (fill_inc == len_q) begin
                    state_d = ST_ARMED;
                end
            end
            // Non-overlap: the next match must be built from len fresh bits.
            if (match && !ovl_q) begin
                state_d = ST_FILL;
                fill_d  = '0;
            end
        end
        if (load_ok) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = ST_FILL;
        end
    end

    always_comb begin
        detect_d  = match;
        cfg_err_d = cfg_load && !len_ok;
        armed_d   = (state_d == ST_ARMED);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (cnt_clr),
        .inc_i   (match),
        .count_o (match_count)
    );

    assign detect  = detect_q;
    assign cfg_err = cfg_err_q;
    assign armed   = armed_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus random traffic against a queue-based model.
module tb_seq_detect_prog;

    localparam int PAT_W = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             inbits;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             detect, detect2;
    logic [7:0]       match_count;
    logic [1:0]       match_count2;
    logic             cfg_err, cfg_err2;
    logic             armed, armed2;

    int total = 0;
    int bad   = 0;

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .inbits      (inbits),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .detect      (detect),
        .match_count (match_count),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .inbits      (inbits),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .detect      (detect2),
        .match_count (match_count2),
        .cfg_err     (cfg_err2),
        .armed       (armed2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the bits accepted since the last restart, plus the active config.
    bit         m_cfg;
    bit [7:0]   m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_bits[$];
    int         m_cnt, m_cnt2;
    bit         e_det, e_err, e_arm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit m;
        bit ok;
        m = 1'b0;
        if (!reset) begin
            m_cfg = 1'b0; m_pat = '0; m_len = 1; m_ovl = 1'b0;
            m_bits.delete();
            m_cnt = 0; m_cnt2 = 0;
            e_det = 1'b0; e_err = 1'b0; e_arm = 1'b0;
            return;
        end
        if (m_cfg && in_valid) begin
            m_bits.push_back(inbits);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            if (m_bits.size() >= m_len) begin
                ok = 1'b1;
                for (int k = 0; k < m_len; k++)
                    if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) ok = 1'b0;
                m = ok;
                if (m && !m_ovl) m_bits.delete();
            end
        end
        e_err = cfg_load && !(cfg_len >= 1 && cfg_len <= PAT_W);
        if (cfg_load && !e_err) begin
            m_cfg = 1'b1; m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
            m_bits.delete();
        end
        if (cnt_clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (m) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        e_det = m;
        e_arm = m_cfg && (m_bits.size() >= m_len);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("detect", 32'(detect), 32'(e_det));
        chk("match_count", 32'(match_count), 32'(m_cnt));
        chk("match_count_w2", 32'(match_count2), 32'(m_cnt2));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
        chk("armed", 32'(armed), 32'(e_arm));
        chk("detect_w2", 32'(detect2), 32'(e_det));
    endtask

    task automatic idle_inputs();
        reset = 1'b1; in_valid = 1'b0; inbits = 1'b0; cfg_load = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            in_valid = 1'b1; inbits = bits[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_count();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        // Unconfigured: bits must be ignored.
        send(16'b1011, 4);

        // 1011 non-overlap over 1011011
        load(8'b1011, 4'd4, 1'b0);
        send(16'b1011011, 7);
        chk("nonovl_count", 32'(match_count), 32'd1);
        clear_count();

        // 1011 overlap over 1011011
        load(8'b1011, 4'd4, 1'b1);
        send(16'b1011011, 7);
        chk("ovl_count", 32'(match_count), 32'd2);
        clear_count();

        // in_valid gaps are transparent
        load(8'b1011, 4'd4, 1'b0);
        send(16'b10, 2);
        gap(3);
        send(16'b11, 2);
        gap(1);

        // illegal lengths leave the previous pattern in force
        load(8'hFF, 4'd0, 1'b1);
        load(8'hFF, 4'd9, 1'b1);
        send(16'b1011, 4);
        gap(1);

        // saturation on the 2-bit counter, then clear racing a match
        load(8'b1, 4'd1, 1'b0);
        send(16'b11111, 5);
        chk("sat_count_w2", 32'(match_count2), 32'd3);
        in_valid = 1'b1; inbits = 1'b1; cnt_clr = 1'b1;
        step();
        in_valid = 1'b0; cnt_clr = 1'b0;
        chk("clr_wins", 32'(match_count2), 32'd0);

        // match coincident with a reload still counts
        load(8'b1011, 4'd4, 1'b1);
        send(16'b101, 3);
        in_valid = 1'b1; inbits = 1'b1;
        load(8'b0110, 4'd4, 1'b0);
        in_valid = 1'b0;
        send(16'b0110, 4);
        gap(1);

        // reset mid-fill returns to idle and ignores bits until reloaded
        load(8'b1011, 4'd4, 1'b0);
        send(16'b101, 3);
        reset = 1'b0; in_valid = 1'b1; inbits = 1'b1; cfg_load = 1'b1; cnt_clr = 1'b1;
        cfg_len = 4'd2;
        step();
        idle_inputs();
        chk("rst_armed", 32'(armed), 32'd0);
        send(16'b1011011, 7);
        load(8'b11, 4'd2, 1'b1);
        send(16'b0111, 4);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            reset       = ($urandom_range(0, 199) != 0);
            cfg_load    = ($urandom_range(0, 39) == 0);
            cfg_pattern = 8'($urandom());
            cfg_len     = 4'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom());
            in_valid    = ($urandom_range(0, 3) != 0);
            inbits      = 1'($urandom());
            cnt_clr     = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 99) == 0) begin
                cfg_load = 1'b1; cfg_len = 4'd1;
            end
            step();
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: inbits is sampled only when in_valid=1.
REQ-006 The block SHALL have port inbits, input, 1 bit: the serial data bit.
REQ-007 The block SHALL have port cfg_load, input, 1 bit: a one-cycle request to load cfg_pattern, cfg_len and cfg_overlap.
REQ-008 The block SHALL have port cfg_pattern, input, PAT_W bits: the pattern, right-aligned; bit [len-1] is the first bit received.
REQ-009 The block SHALL have port cfg_len, input, $clog2(PAT_W+1) bits: the pattern length; legal range 1..PAT_W.
REQ-010 The block SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping detection and 0 selects non-overlapping detection.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_count.
REQ-012 The block SHALL have port detect, output, 1 bit, registered: a one-cycle match pulse.
REQ-013 The block SHALL have port match_count, output, CNT_W bits, registered: a saturating count of matches.
REQ-014 The block SHALL have port cfg_err, output, 1 bit, registered: a one-cycle pulse flagging a rejected configuration.
REQ-015 The block SHALL have port armed, output, 1 bit, registered: 1 when the block is in state ARMED.

Function
REQ-016 The block SHALL hold a PAT_W-bit history shift register; each accepted bit shifts in at the LSB.
REQ-017 The block SHALL have FSM states IDLE, FILL and ARMED.
- IDLE: unconfigured; input bits are ignored.
- FILL: fewer than len bits have been accepted since the last clear.
- ARMED: the history holds at least len valid bits.
REQ-018 A legal cfg_load in any state SHALL:
- latch the configuration;
- clear the history and the fill count;
- move the FSM to FILL on the next edge.
A bit presented with in_valid in the same cycle is discarded.
REQ-019 An illegal cfg_load (cfg_len=0 or cfg_len>PAT_W) SHALL:
- pulse cfg_err for one cycle;
- leave the configuration, state and history unchanged.
REQ-020 In FILL, each accepted bit SHALL increment the fill count; the FSM SHALL enter ARMED on the edge at which the count reaches len.
REQ-021 A match SHALL occur when the FSM is in ARMED and the low len bits of the history equal the low len bits of the pattern; in FILL, a match is evaluated on the same edge that completes the fill.
REQ-022 The block SHALL assert detect for exactly one cycle, starting at edge N+1, where edge N accepted the completing bit (latency 1).
REQ-023 In overlap mode, the FSM SHALL remain in ARMED after a match, so the trailing bits of one match may begin the next.
REQ-024 In non-overlap mode, on a match the block SHALL:
- clear the fill count;
- return the FSM to FILL.
A new match then needs len fresh bits.
REQ-025 When in_valid=0, the block SHALL leave the history, state and fill count unchanged; gaps in in_valid are transparent.
REQ-026 On each match, match_count SHALL increment and saturate at 2^CNT_W-1.
REQ-027 cnt_clr SHALL force match_count to 0 and SHALL take priority over a simultaneous increment.
REQ-028 A match SHALL be counted and detected even when cfg_load is asserted in the same cycle, because match evaluation uses the pre-load configuration.
REQ-029 When cfg_len=1, every accepted bit equal to pattern[0] SHALL match, in either mode.

Reset
REQ-030 When reset=0 at a rising edge, the block SHALL set:
- state to IDLE;
- history, fill count and match_count to 0;
- detect, cfg_err and armed to 0;
- pattern register to 0, len register to 1, overlap register to 0.
REQ-031 Reset SHALL override cfg_load, cnt_clr and in_valid in the same cycle; there is no asynchronous path.

Structure
REQ-032 A shared package seq_detect_pkg SHALL hold the FSM state enum and the default PAT_W and CNT_W constants.
REQ-033 A sub-module sat_counter (CNT_W, with clear and increment) SHALL implement match_count; all other logic stays in seq_detect_prog.

Verification
REQ-034 Load pattern 1011 (len=4, overlap=0), drive 1011011 -> a single detect pulse one cycle after the 4th bit, and match_count=1.
REQ-035 Same pattern with overlap=1, drive 1011011 -> detect pulses after bit 4 and after bit 7, and match_count=2.
REQ-036 Drive 10 then in_valid=0 for 3 cycles, then 11 -> detect one cycle after the final 1; no pulse during the gap.
REQ-037 cfg_load with cfg_len=0, then cfg_len=PAT_W+1 -> two cfg_err pulses and the previous pattern still detected.
REQ-038 CNT_W=2 with 5 matches, then cnt_clr coincident with a 6th match -> count saturates at 3, then reads 0.
REQ-039 Assert reset=0 mid-FILL with a partial 101 in history -> all outputs 0 and state IDLE; input bits are ignored until the next cfg_load.
